// File: rtl/a7link_sequencer.sv
`timescale 1ns/1ps
// Hardware sequencer for one read/write transaction over the serial link to the remote bus FSM:
// serializes a 5-frame command, collects the framed reply, reports data, status and timeout.
module a7link_sequencer #(
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned GAP     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] rd_data,
  output logic [7:0]  rd_status,
  output logic        timeout,
  output logic        ser_out,
  input  logic        ser_in,
  output logic [15:0] n_txn,
  output logic [15:0] n_tmo
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND, S_GAPW, S_WAITR, S_RECV, S_FIN
  } state_t;

  state_t         state_q, state_d;
  logic           wr_q, wr_d;
  logic [15:0]    addr_q, addr_d;
  logic [15:0]    wdata_q, wdata_d;
  logic [2:0]     frm_q, frm_d;
  logic [3:0]     bit_q, bit_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           ser_out_q, ser_out_d;
  logic           sin_q;
  logic [11:0]    rx_sr_q, rx_sr_d;
  logic [1:0]     rx_cnt_q, rx_cnt_d;
  logic [7:0]     hi_q, hi_d;
  logic [7:0]     lo_q, lo_d;
  logic [15:0]    rd_data_q, rd_data_d;
  logic [7:0]     rd_status_q, rd_status_d;
  logic           timeout_q, timeout_d;
  logic [15:0]    n_txn_q, n_txn_d;
  logic [15:0]    n_tmo_q, n_tmo_d;

  logic [7:0]     cur_byte;
  logic [11:0]    cur_frame;
  logic           frame_end, last_frame, gap_end;
  logic           in_rx, rx_det, rx_flag, rx_end, tmo_hit;
  logic [7:0]     rx_byte;

  always_comb begin
    case (frm_q)
      3'd0:    cur_byte = addr_q[15:8];
      3'd1:    cur_byte = addr_q[7:0];
      3'd2:    cur_byte = wr_q ? wdata_q[15:8] : 8'h00;
      3'd3:    cur_byte = wr_q ? wdata_q[7:0]  : 8'h00;
      default: cur_byte = wr_q ? 8'h02 : 8'h01;
    endcase
  end

  assign cur_frame  = {1'b1, (frm_q == 3'd4), cur_byte, 2'b00};
  assign frame_end  = (state_q == S_SEND) && (bit_q == 4'd11);
  assign last_frame = (frm_q == 3'd4);
  assign gap_end    = (state_q == S_GAPW) && (gap_q == GAP_LAST);

  assign in_rx   = (state_q == S_WAITR) || (state_q == S_RECV);
  assign rx_det  = rx_sr_q[11] && (rx_sr_q[1:0] == 2'b00);
  assign rx_flag = rx_sr_q[10];
  assign rx_byte = rx_sr_q[9:2];
  assign rx_end  = in_rx && rx_det && rx_flag;
  assign tmo_hit = in_rx && !rx_end && (tmo_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      frm_q       <= '0;
      bit_q       <= '0;
      gap_q       <= '0;
      tmo_q       <= '0;
      ser_out_q   <= 1'b0;
      sin_q       <= 1'b0;
      rx_sr_q     <= '0;
      rx_cnt_q    <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      rd_data_q   <= '0;
      rd_status_q <= '0;
      timeout_q   <= 1'b0;
      n_txn_q     <= '0;
      n_tmo_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      frm_q       <= frm_d;
      bit_q       <= bit_d;
      gap_q       <= gap_d;
      tmo_q       <= tmo_d;
      ser_out_q   <= ser_out_d;
      sin_q       <= ser_in;
      rx_sr_q     <= rx_sr_d;
      rx_cnt_q    <= rx_cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      rd_data_q   <= rd_data_d;
      rd_status_q <= rd_status_d;
      timeout_q   <= timeout_d;
      n_txn_q     <= n_txn_d;
      n_tmo_q     <= n_tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req) state_d = S_LOAD;
      S_LOAD:  state_d = S_SEND;
      S_SEND: begin
        if (frame_end) begin
          if (last_frame)    state_d = S_WAITR;
          else if (GAP == 0) state_d = S_SEND;
          else               state_d = S_GAPW;
        end
      end
      S_GAPW:  if (gap_end) state_d = S_SEND;
      S_WAITR: begin
        if (rx_end || tmo_hit) state_d = S_FIN;
        else if (rx_det)       state_d = S_RECV;
      end
      S_RECV:  if (rx_end || tmo_hit) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ser_out_q always carries the bit selected by bit_q, so every frame entry loads the start bit.
  always_comb begin
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    frm_d       = frm_q;
    bit_d       = bit_q;
    gap_d       = gap_q;
    tmo_d       = tmo_q;
    ser_out_d   = 1'b0;
    rx_cnt_d    = rx_cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    rd_data_d   = rd_data_q;
    rd_status_d = rd_status_q;
    timeout_d   = timeout_q;
    n_txn_d     = n_txn_q;
    n_tmo_d     = n_tmo_q;
    rx_sr_d     = rx_det ? {11'b0, sin_q} : {rx_sr_q[10:0], sin_q};

    case (state_q)
      S_IDLE: begin
        if (req) begin
          wr_d    = req_wr;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      S_LOAD: begin
        frm_d     = '0;
        bit_d     = '0;
        tmo_d     = '0;
        rx_cnt_d  = '0;
        hi_d      = '0;
        lo_d      = '0;
        ser_out_d = 1'b1;
      end
      S_SEND: begin
        if (frame_end) begin
          bit_d = '0;
          gap_d = '0;
          if (!last_frame && (GAP == 0)) begin
            frm_d     = frm_q + 3'd1;
            ser_out_d = 1'b1;
          end
        end else begin
          bit_d     = bit_q + 4'd1;
          ser_out_d = cur_frame[4'd10 - bit_q];
        end
      end
      S_GAPW: begin
        gap_d = gap_q + GW'(1);
        if (gap_end) begin
          frm_d     = frm_q + 3'd1;
          bit_d     = '0;
          ser_out_d = 1'b1;
        end
      end
      S_WAITR, S_RECV: begin
        tmo_d = tmo_q + TW'(1);
        if (rx_end) begin
          // Missing data bytes of a short reply read back as zero because LOAD cleared them.
          rd_data_d   = {hi_q, lo_q};
          rd_status_d = rx_byte;
          timeout_d   = 1'b0;
        end else if (tmo_hit) begin
          rd_data_d   = 16'hFFFF;
          rd_status_d = 8'hFF;
          timeout_d   = 1'b1;
        end else if (rx_det) begin
          case (rx_cnt_q)
            2'd0: begin hi_d = rx_byte; rx_cnt_d = 2'd1; end
            2'd1: begin lo_d = rx_byte; rx_cnt_d = 2'd2; end
            default: rx_cnt_d = rx_cnt_q;
          endcase
        end
      end
      S_FIN: begin
        n_txn_d = n_txn_q + 16'd1;
        n_tmo_d = n_tmo_q + {15'b0, timeout_q};
      end
      default: ;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE) && (state_q != S_FIN);
    done      = (state_q == S_FIN);
    rd_data   = rd_data_q;
    rd_status = rd_status_q;
    timeout   = timeout_q;
    ser_out   = ser_out_q;
    n_txn     = n_txn_q;
    n_tmo     = n_tmo_q;
  end

endmodule

// File: tb/tb_a7link_sequencer.sv
`timescale 1ns/1ps
// Bench for a7link_sequencer: table-driven transactions, reset/abort and req-ignore sequences,
// then random transactions checked against a reply model built from the link framing rules.
module tb_a7link_sequencer;

  localparam int unsigned TMO = 64;
  localparam int unsigned GP  = 2;

  logic        clk = 1'b0;
  logic        rst, req, req_wr, ser_in;
  logic [15:0] req_addr, req_wdata;
  logic        busy, done, timeout, ser_out;
  logic [15:0] rd_data, n_txn, n_tmo;
  logic [7:0]  rd_status;

  a7link_sequencer #(.TIMEOUT(TMO), .GAP(GP)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .busy(busy), .done(done), .rd_data(rd_data),
    .rd_status(rd_status), .timeout(timeout), .ser_out(ser_out), .ser_in(ser_in),
    .n_txn(n_txn), .n_tmo(n_tmo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;
  int m_txn = 0;
  int m_tmo = 0;

  // TX line monitor: collects 12-bit frames and their start cycles
  logic [11:0] txq[$];
  int          fstart[$];
  int          flast;
  int          bitpos = 0;
  logic [11:0] fsh;
  always @(negedge clk) begin
    if (rst) begin
      bitpos = 0;
    end else if (bitpos == 0) begin
      if (ser_out) begin
        fsh    = 12'd1;
        bitpos = 1;
        fstart.push_back(cyc);
      end
    end else begin
      fsh = {fsh[10:0], ser_out};
      bitpos++;
      if (bitpos == 12) begin
        txq.push_back(fsh);
        flast  = cyc;
        bitpos = 0;
      end
    end
  end

  int done_cnt = 0;
  always @(negedge clk) if (done) done_cnt++;

  typedef struct {
    logic            wr;
    logic [15:0]     addr;
    logic [15:0]     wdata;
    int              nrep;
    logic [3:0][7:0] rep;
    int              flagpos;
    int              gapc;
    int              dly;
    logic            pulse_busy;
    logic            done_pulse;
    logic [15:0]     ed;
    logic [7:0]      es;
    logic            et;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at cycle %0d", nm, cyc);
  endtask

  // Reply rules: flagged frame supplies status; data bytes are the frames before it, absent ones zero.
  function automatic vec_t model_reply(input vec_t v);
    vec_t r = v;
    if (v.flagpos < 0) begin
      r.ed = 16'hFFFF;
      r.es = 8'hFF;
      r.et = 1'b1;
    end else begin
      r.ed[15:8] = (v.flagpos >= 1) ? v.rep[0] : 8'h00;
      r.ed[7:0]  = (v.flagpos >= 2) ? v.rep[1] : 8'h00;
      r.es       = v.rep[v.flagpos];
      r.et       = 1'b0;
    end
    return r;
  endfunction

  task automatic send_frame(input logic flag, input logic [7:0] b);
    logic [11:0] f;
    f = {1'b1, flag, b, 2'b00};
    for (int i = 11; i >= 0; i--) begin
      ser_in = f[i];
      @(negedge clk);
    end
    ser_in = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    int c, d0, dc;
    logic got;
    logic [7:0] eb[5];
    logic [11:0] ef;
    eb = '{v.addr[15:8], v.addr[7:0], v.wr ? v.wdata[15:8] : 8'h00,
           v.wr ? v.wdata[7:0] : 8'h00, v.wr ? 8'h02 : 8'h01};
    txq.delete();
    fstart.delete();
    d0 = done_cnt;
    req = 1'b1; req_wr = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    c = cyc;
    @(negedge clk);
    chk("busy_after_req", {31'b0, busy}, 32'd1);
    req = 1'b0;
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);
    if (v.pulse_busy) begin
      repeat (10) @(negedge clk);
      req = 1'b1; req_wr = ~v.wr;
      @(negedge clk);
      req = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (txq.size() >= 5) begin got = 1'b1; break; end
    end
    if (!got) begin
      bound_fail("tx_frames");
      @(negedge clk);
      return;
    end
    for (int k = 0; k < 5; k++) begin
      ef = {1'b1, (k == 4), eb[k], 2'b00};
      chk($sformatf("tx_frame%0d", k), {20'b0, txq[k]}, {20'b0, ef});
      if (k > 0) chk($sformatf("tx_spacing%0d", k), fstart[k] - fstart[k-1], 12 + GP);
    end
    chk("tx_first_bit_latency", fstart[0] - c, 2);
    @(negedge clk);
    repeat (v.dly) @(negedge clk);
    for (int f = 0; f < v.nrep; f++) begin
      send_frame(f == v.flagpos, v.rep[f]);
      if (f != v.nrep - 1) repeat (v.gapc) @(negedge clk);
    end
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) begin
      bound_fail("done_wait");
      return;
    end
    dc = cyc;
    chk("rd_data", {16'b0, rd_data}, {16'b0, v.ed});
    chk("rd_status", {24'b0, rd_status}, {24'b0, v.es});
    chk("timeout", {31'b0, timeout}, {31'b0, v.et});
    chk("busy_at_done", {31'b0, busy}, 32'd0);
    if (v.flagpos < 0) chk("timeout_latency", dc - flast, TMO + 1);
    if (v.done_pulse) begin
      req = 1'b1;
      @(negedge clk);
      chk("req_in_done_ignored_a", {31'b0, busy}, 32'd0);
      req = 1'b0;
      @(negedge clk);
      chk("req_in_done_ignored_b", {31'b0, busy}, 32'd0);
    end else begin
      @(negedge clk);
    end
    m_txn++;
    if (v.et) m_tmo++;
    chk("n_txn", {16'b0, n_txn}, 32'(m_txn & 16'hFFFF));
    chk("n_tmo", {16'b0, n_tmo}, 32'(m_tmo & 16'hFFFF));
    @(posedge clk);
    chk("done_pulses", done_cnt - d0, 1);
    @(negedge clk);
  endtask

  vec_t tbl[8];
  vec_t v;

  initial begin
    // fields: wr addr wdata nrep rep{3,2,1,0} flagpos gap dly pulse_busy done_pulse | data status tmo
    tbl[0] = '{1'b1, 16'h0003, 16'h1234, 3, 32'h00000000,  2, 0, 1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0};
    tbl[1] = '{1'b0, 16'h0001, 16'hDEAD, 3, 32'h0000EFBE,  2, 1, 0, 1'b1, 1'b0, 16'hBEEF, 8'h00, 1'b0};
    tbl[2] = '{1'b0, 16'h0002, 16'h0000, 0, 32'h00000000, -1, 0, 0, 1'b0, 1'b1, 16'hFFFF, 8'hFF, 1'b1};
    tbl[3] = '{1'b0, 16'h0010, 16'h5555, 1, 32'h0000005A,  0, 0, 2, 1'b0, 1'b0, 16'h0000, 8'h5A, 1'b0};
    tbl[4] = '{1'b0, 16'h0020, 16'h0000, 2, 32'h00003412,  1, 2, 0, 1'b0, 1'b0, 16'h1200, 8'h34, 1'b0};
    tbl[5] = '{1'b1, 16'hA5A5, 16'hFFFF, 4, 32'h44332211,  3, 2, 3, 1'b0, 1'b0, 16'h1122, 8'h44, 1'b0};
    tbl[6] = '{1'b0, 16'h0030, 16'h0000, 2, 32'h00002211, -1, 1, 0, 1'b0, 1'b0, 16'hFFFF, 8'hFF, 1'b1};
    tbl[7] = '{1'b1, 16'h7FFF, 16'h8001, 3, 32'h0000CDAB,  2, 0, 0, 1'b0, 1'b0, 16'hABCD, 8'h00, 1'b0};

    rst = 1'b1; req = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; ser_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_rd_data", {16'b0, rd_data}, 32'd0);
    chk("rst_rd_status", {24'b0, rd_status}, 32'd0);
    chk("rst_timeout", {31'b0, timeout}, 32'd0);
    chk("rst_ser_out", {31'b0, ser_out}, 32'd0);
    chk("rst_n_txn", {16'b0, n_txn}, 32'd0);
    chk("rst_n_tmo", {16'b0, n_tmo}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (tbl[i]) run_txn(tbl[i]);

    begin : abort_mid_frame3
      int d0;
      logic got;
      txq.delete();
      fstart.delete();
      d0 = done_cnt;
      req = 1'b1; req_wr = 1'b1; req_addr = 16'h1111; req_wdata = 16'h2222;
      @(negedge clk);
      req = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(posedge clk);
        if (fstart.size() >= 3) begin got = 1'b1; break; end
      end
      if (!got) bound_fail("abort_frame3_wait");
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_ser_out", {31'b0, ser_out}, 32'd0);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      @(posedge clk);
      chk("abort_no_done", done_cnt - d0, 0);
      @(negedge clk);
      m_txn = 0;
      m_tmo = 0;
      chk("abort_n_txn", {16'b0, n_txn}, 32'd0);
      v = '{1'b0, 16'h0001, 16'h0000, 3, 32'h0000EFBE, 2, 0, 0, 1'b0, 1'b0, 16'hBEEF, 8'h00, 1'b0};
      run_txn(v);
    end

    for (int n = 0; n < 16; n++) begin
      v.wr    = 1'($urandom_range(0, 1));
      v.addr  = 16'($urandom);
      v.wdata = 16'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        v.flagpos = -1;
        v.nrep    = $urandom_range(0, 2);
      end else begin
        v.flagpos = $urandom_range(0, 3);
        v.nrep    = v.flagpos + 1;
      end
      v.rep        = 32'($urandom);
      v.gapc       = $urandom_range(0, 2);
      v.dly        = $urandom_range(0, 3);
      v.pulse_busy = 1'($urandom_range(0, 1));
      v.done_pulse = 1'b0;
      v = model_reply(v);
      run_txn(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1);
  end

endmodule
